// File: rtl/cache_wbuf_bridge_if.sv
// Valid/ready memory bus shared by the cache RAM side and the main-memory side.
interface cache_wbuf_bridge_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             instr;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [3:0]       wstrb;
  logic             ready;
  logic [WIDTH-1:0] rdata;

  modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/cache_wbuf_bridge.sv
// Posted-write buffer between the cache RAM port (up) and main memory (dn).
// Define WBUF_FORWARD_EN to let reads take data from the youngest full-word buffered write.
//   state | meaning
//   IDLE  | nothing outstanding downstream
//   DRAIN | head buffer entry presented to memory
//   READ  | upstream read presented to memory
//   RESP  | captured read data returned to the cache
module cache_wbuf_bridge #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 2
) (
  input  logic                clk,
  input  logic                resetn,
  cache_wbuf_bridge_if.slave  up,
  cache_wbuf_bridge_if.master dn,
  output logic [DEPTH_BITS:0] wbuf_count,
  output logic                wbuf_full
);
  localparam int                    DEPTH     = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   CNT_ONE   = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE   = DEPTH_BITS'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]      fifo_addr [DEPTH];
  logic [WIDTH-1:0]      fifo_data [DEPTH];
  logic [3:0]            fifo_strb [DEPTH];
  logic [DEPTH_BITS-1:0] head, tail;
  logic [DEPTH_BITS:0]   count;

  logic             ready_q;
  logic [WIDTH-1:0] rdata_q;
  logic             mem_valid_q, mem_instr_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_wstrb_q;

  logic             wr_acc, rd_req, rd_go, fwd_ok, fwd_take;
  logic [WIDTH-1:0] fwd_data;
  logic             load_drain, load_read, pop, capture;

  // ready_q doubles as "response pending": nothing new is accepted during the ack cycle
  assign wr_acc = up.valid && (up.wstrb != 4'b0000) && !ready_q && (count < DEPTH_CNT);
  assign rd_req = up.valid && (up.wstrb == 4'b0000) && !ready_q;
  assign rd_go  = rd_req && !fwd_ok;

`ifdef WBUF_FORWARD_EN
  logic [DEPTH_BITS-1:0] scan_idx;
  logic                  hit_any;
  logic [3:0]            hit_strb;

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    scan_idx = head;
    hit_any  = 1'b0;
    hit_strb = 4'b0000;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + DEPTH_BITS'(i);
      if (((DEPTH_BITS+1)'(i) < count) &&
          (fifo_addr[scan_idx][WIDTH-1:2] == up.addr[WIDTH-1:2])) begin
        hit_any  = 1'b1;
        hit_strb = fifo_strb[scan_idx];
        fwd_data = fifo_data[scan_idx];
      end
    end
  end

  assign fwd_ok   = hit_any && (hit_strb == 4'b1111);
  assign fwd_take = rd_req && fwd_ok && ((state == IDLE) || (state == DRAIN));
`else
  assign fwd_ok   = 1'b0;
  assign fwd_take = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_drain = 1'b0;
    load_read  = 1'b0;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt  = DRAIN;
          load_drain = 1'b1;
        end else if (rd_go) begin
          state_nxt = READ;
          load_read = 1'b1;
        end
      end
      DRAIN: begin
        if (dn.ready) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      READ: begin
        if (dn.ready) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      fifo_addr[tail] <= up.addr;
      fifo_data[tail] <= up.wdata;
      fifo_strb[tail] <= up.wstrb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
    end else begin
      ready_q <= wr_acc || capture || fwd_take;
      if (wr_acc) tail <= tail + PTR_ONE;
      if (pop)    head <= head + PTR_ONE;
      if (wr_acc && !pop)      count <= count + CNT_ONE;
      else if (pop && !wr_acc) count <= count - CNT_ONE;
      if (capture)       rdata_q <= dn.rdata;
      else if (fwd_take) rdata_q <= fwd_data;
      if (load_drain) begin
        mem_valid_q <= 1'b1;
        mem_instr_q <= 1'b0;
        mem_addr_q  <= fifo_addr[head];
        mem_wdata_q <= fifo_data[head];
        mem_wstrb_q <= fifo_strb[head];
      end else if (load_read) begin
        mem_valid_q <= 1'b1;
        mem_instr_q <= up.instr;
        mem_addr_q  <= up.addr;
        mem_wdata_q <= up.wdata;
        mem_wstrb_q <= 4'b0000;
      end else if (dn.ready) begin
        mem_valid_q <= 1'b0;
      end
    end
  end

  assign up.ready   = ready_q;
  assign up.rdata   = rdata_q;
  assign dn.valid   = mem_valid_q;
  assign dn.instr   = mem_instr_q;
  assign dn.addr    = mem_addr_q;
  assign dn.wdata   = mem_wdata_q;
  assign dn.wstrb   = mem_wstrb_q;
  assign wbuf_count = count;
  assign wbuf_full  = (count == DEPTH_CNT);
endmodule
